// File: rtl/mem_responder_if.sv
// CPU <-> memory responder bus: request fields driven by the CPU, completion
// fields driven by the responder.
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        addr_err;

  // Handshake: req is sampled only on an edge where busy=0 (IDLE or DONE).
  // That edge latches every request field. ready is a one-cycle pulse
  // (WAIT_STATES+1) edges later. addr_err and a fresh rdata are meaningful
  // only while ready=1. A req seen while busy=1 is dropped, never queued.
  modport master (
    output req, wr, addr, size, wdata,
    input  rdata, ready, busy, addr_err
  );

  modport slave (
    input  req, wr, addr, size, wdata,
    output rdata, ready, busy, addr_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM answering CPU byte/half/word accesses after a fixed number
// of wait states; reads are right-aligned and zero-extended.
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus,
  output logic [1:0]      dbg_state
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q;
  logic                   wr_q;
  logic [31:0]            addr_q;
  logic [1:0]             size_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic                   err_q;

  logic [31:0]            mem [DEPTH];

  logic                   accept;
  logic                   finish;
  logic                   access_err;
  logic [ADDR_BITS-1:0]   word_idx;
  logic [31:0]            cur_word;
  logic [31:0]            read_val;
  logic [3:0]             lane_mask;
  logic [31:0]            lane_data;

  assign accept   = bus.req && (state_q != S_WAIT);
  assign finish   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign word_idx = addr_q[ADDR_BITS+1:2];
  assign cur_word = mem[word_idx];

  // Rejections: illegal size, misalignment, or any address bit above the RAM.
  always_comb begin
    access_err = 1'b0;
    if (size_q == 2'b11)                          access_err = 1'b1;
    if (size_q == 2'b01 && addr_q[0])             access_err = 1'b1;
    if (size_q == 2'b00 && addr_q[1:0] != 2'b00)  access_err = 1'b1;
    if ((addr_q >> (ADDR_BITS + 2)) != 32'd0)     access_err = 1'b1;
  end

  always_comb begin
    read_val = 32'd0;
    case (size_q)
      2'b00:   read_val = cur_word;
      2'b01:   read_val = {16'd0, addr_q[1] ? cur_word[31:16] : cur_word[15:0]};
      2'b10:   read_val = {24'd0, cur_word[8*addr_q[1:0] +: 8]};
      default: read_val = 32'd0;
    endcase
  end

  // Replicate the right-aligned data into every lane; the mask picks the lanes.
  always_comb begin
    lane_mask = 4'b0000;
    lane_data = wdata_q;
    case (size_q)
      2'b00: lane_mask = 4'b1111;
      2'b01: begin
        lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        lane_mask = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      default: lane_mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:  state_d = bus.req ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= finish && access_err;
      if (accept) begin
        wr_q    <= bus.wr;
        addr_q  <= bus.addr;
        size_q  <= bus.size;
        wdata_q <= bus.wdata;
        cnt_q   <= 4'(WAIT_STATES);
      end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (finish) begin
        if (access_err)
          rdata_q <= 32'd0;
        else if (!wr_q)
          rdata_q <= read_val;
      end
    end
  end

  // RAM has no reset; the reset level also blocks a write on the same edge.
  always_ff @(posedge clock) begin
    if (reset && finish && wr_q && !access_err) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_mask[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ready    = (state_q == S_DONE);
  assign bus.busy     = (state_q == S_WAIT);
  assign bus.addr_err = err_q;
  assign dbg_state    = state_q;

endmodule
